// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared fetch types and constants: the queued instruction entry (also consumed by decode),
// the ECALL encoding and the instruction size.
package fetch_pkg;

  localparam int ENTRY_XLEN = 64;
  localparam int ENTRY_ILEN = 32;
  localparam logic [31:0] ECALL_INST = 32'h0000_0073;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [ENTRY_XLEN-1:0] pc;
    logic [ENTRY_ILEN-1:0] inst;
    logic                  is_ecall;
  } fetch_entry_t;

  function automatic logic is_ecall_inst(input logic [ENTRY_ILEN-1:0] inst);
    return inst == ECALL_INST;
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Icache request/response and decode handshake bundle of the prefetch queue.
// The fetch unit uses master; the icache/decode environment uses slave.
interface fetch_prefetch_queue_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic            ic_req_valid;
  logic            ic_req_ready;
  logic [XLEN-1:0] ic_req_pc;
  logic            ic_resp_valid;
  logic [ILEN-1:0] ic_resp_inst;
  logic [XLEN-1:0] ic_resp_pc;
  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_is_ecall;

  modport master (
    output ic_req_valid, ic_req_pc, out_valid, out_inst, out_pc, out_is_ecall,
    input  ic_req_ready, ic_resp_valid, ic_resp_inst, ic_resp_pc, out_ready
  );

  modport slave (
    input  ic_req_valid, ic_req_pc, out_valid, out_inst, out_pc, out_is_ecall,
    output ic_req_ready, ic_resp_valid, ic_resp_inst, ic_resp_pc, out_ready
  );
endinterface

// File: rtl/fetch_prefetch_queue_fifo.sv
// Synchronous FIFO of fetch entries with flush. A push into a full FIFO is accepted
// only together with a pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  cnt_r;
  logic           do_push_s;
  logic           do_pop_s;

  assign empty     = (cnt_r == '0);
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & ((cnt_r != CW'(DEPTH)) | do_pop_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = cnt_r;

  // Pointer and count bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Entry storage; contents beyond count are don't-care and masked at the output.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Prefetching fetch stage: issues in-order icache requests under a FIFO credit limit,
// drops stale responses after redirects or an ECALL, and feeds decode via valid/ready.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ILEN = 32,
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int IW = $clog2(MAX_OUTSTANDING + 1),
  localparam int OW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_enable,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_prefetch_queue_if.master bus,
  output logic            ecall_halted,
  output logic [IW-1:0]   inflight,
  output logic [OW-1:0]   occupancy
);

  localparam int CW = $clog2(DEPTH + MAX_OUTSTANDING + 1) + 1;

  logic [XLEN-1:0] fetch_pc_r;
  logic [IW-1:0]   inflight_r;
  logic [IW-1:0]   drop_cnt_r;
  logic            halted_r;
  logic [CW-1:0]   credit_used_s;
  logic            req_valid_s;
  logic            req_fire_s;
  logic            resp_keep_s;
  logic            pop_s;
  logic [IW-1:0]   inflight_next_s;
  fetch_entry_t    push_entry_s;
  fetch_entry_t    head_s;
  logic            fifo_empty_s;

  // Queued entries plus responses still owed to the FIFO (in flight minus those to be dropped).
  assign credit_used_s = CW'(occupancy) + CW'(inflight_r) - CW'(drop_cnt_r);
  assign req_valid_s   = fetch_enable & ~halted_r & ~redirect_valid
                       & (inflight_r < IW'(MAX_OUTSTANDING))
                       & (credit_used_s < CW'(DEPTH));
  assign req_fire_s    = req_valid_s & bus.ic_req_ready;
  assign resp_keep_s   = bus.ic_resp_valid & ~redirect_valid & (drop_cnt_r == '0);
  assign pop_s         = ~fifo_empty_s & bus.out_ready;
  assign inflight_next_s = inflight_r + IW'(req_fire_s) - IW'(bus.ic_resp_valid);

  // Pack the incoming response and classify it once at push time.
  always_comb begin
    push_entry_s          = '0;
    push_entry_s.pc       = ENTRY_XLEN'(bus.ic_resp_pc);
    push_entry_s.inst     = ENTRY_ILEN'(bus.ic_resp_inst);
    push_entry_s.is_ecall = is_ecall_inst(push_entry_s.inst);
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (resp_keep_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .head      (head_s),
    .count     (occupancy),
    .empty     (fifo_empty_s)
  );

  // PC, outstanding-request, drop and halt state; redirect overrides everything but reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r <= RESET_PC;
      inflight_r <= '0;
      drop_cnt_r <= '0;
      halted_r   <= 1'b0;
    end else begin
      inflight_r <= inflight_next_s;
      if (redirect_valid) begin
        fetch_pc_r <= redirect_pc;
        halted_r   <= 1'b0;
        drop_cnt_r <= inflight_next_s;
      end else begin
        if (req_fire_s) fetch_pc_r <= fetch_pc_r + XLEN'(INST_BYTES);
        if (resp_keep_s && push_entry_s.is_ecall) begin
          halted_r   <= 1'b1;
          drop_cnt_r <= inflight_next_s;
        end else if (bus.ic_resp_valid && (drop_cnt_r != '0)) begin
          drop_cnt_r <= drop_cnt_r - IW'(1);
        end else begin
          drop_cnt_r <= drop_cnt_r;
        end
      end
    end
  end

  assign bus.ic_req_valid = req_valid_s;
  assign bus.ic_req_pc    = fetch_pc_r;
  assign bus.out_valid    = ~fifo_empty_s;
  assign bus.out_inst     = fifo_empty_s ? '0 : ILEN'(head_s.inst);
  assign bus.out_pc       = fifo_empty_s ? '0 : XLEN'(head_s.pc);
  assign bus.out_is_ecall = ~fifo_empty_s & head_s.is_ecall;
  assign ecall_halted     = halted_r;
  assign inflight         = inflight_r;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench: a per-cycle vector table with hand-computed expectations, then a
// streaming sequence driven by a one-cycle icache model.
module tb_fetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ecall_halted;
  logic [1:0]  inflight;
  logic [2:0]  occupancy;

  int errors = 0;
  int checks = 0;

  fetch_prefetch_queue_if #(.XLEN(64), .ILEN(32)) bus ();

  fetch_prefetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_enable   (fetch_enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .ecall_halted   (ecall_halted),
    .inflight       (inflight),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, fe, rdy, ordy, rv;
    logic [63:0] rpc;
    bit resp_v;
    logic [63:0] resp_pc;
    bit resp_ec;
    bit e_req_v;
    logic [63:0] e_req_pc;
    bit e_out_v;
    logic [63:0] e_out_pc;
    bit e_ec, e_halt;
    int e_infl, e_occ;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return {pc[23:0], 8'h13};
  endfunction

  function automatic vec_t mk(
    input bit rst, fe, rdy, ordy, rv, input logic [63:0] rpc,
    input bit resp_v, input logic [63:0] resp_pc, input bit resp_ec,
    input bit e_req_v, input logic [63:0] e_req_pc,
    input bit e_out_v, input logic [63:0] e_out_pc, input bit e_ec, e_halt,
    input int e_infl, e_occ);
    vec_t v;
    v.rst = rst; v.fe = fe; v.rdy = rdy; v.ordy = ordy; v.rv = rv; v.rpc = rpc;
    v.resp_v = resp_v; v.resp_pc = resp_pc; v.resp_ec = resp_ec;
    v.e_req_v = e_req_v; v.e_req_pc = e_req_pc; v.e_out_v = e_out_v;
    v.e_out_pc = e_out_pc; v.e_ec = e_ec; v.e_halt = e_halt;
    v.e_infl = e_infl; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    fetch_enable = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
    bus.ic_req_ready = 1'b0; bus.ic_resp_valid = 1'b0;
    bus.ic_resp_inst = 32'h0; bus.ic_resp_pc = 64'h0; bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_inst;
    logic        pend_v;
    logic [63:0] pend_pc;
    logic [63:0] exp_pc;
    int          got;
    int          max_infl;

    // rst fe rdy ordy | rv rpc | resp_v resp_pc ec | req_v req_pc | out_v out_pc ec halt infl occ
    // Streaming, one-cycle icache latency
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0, 0,0,  0,0,0,0, 0,0));
    vecs.push_back(mk(0,1,1,1, 0,0, 0,0,0, 1,0,  0,0,0,0, 0,0));
    vecs.push_back(mk(0,1,1,1, 0,0, 1,0,0, 1,4,  0,0,0,0, 1,0));
    vecs.push_back(mk(0,1,1,1, 0,0, 1,4,0, 1,8,  1,0,0,0, 1,1));
    vecs.push_back(mk(0,1,1,1, 0,0, 1,8,0, 1,12, 1,4,0,0, 1,1));
    vecs.push_back(mk(0,0,1,1, 0,0, 1,12,0, 0,16, 1,8,0,0, 1,1));
    vecs.push_back(mk(0,0,1,1, 0,0, 0,0,0, 0,16, 1,12,0,0, 0,1));
    vecs.push_back(mk(0,0,1,1, 0,0, 0,0,0, 0,16, 0,0,0,0, 0,0));
    // Backpressure: fill to DEPTH, issue stops, then in-order drain
    vecs.push_back(mk(0,1,1,0, 0,0, 0,0,0,  1,16, 0,0,0,0,  0,0));
    vecs.push_back(mk(0,1,1,0, 0,0, 1,16,0, 1,20, 0,0,0,0,  1,0));
    vecs.push_back(mk(0,1,1,0, 0,0, 1,20,0, 1,24, 1,16,0,0, 1,1));
    vecs.push_back(mk(0,1,1,0, 0,0, 1,24,0, 1,28, 1,16,0,0, 1,2));
    vecs.push_back(mk(0,1,1,0, 0,0, 1,28,0, 0,32, 1,16,0,0, 1,3));
    vecs.push_back(mk(0,1,1,0, 0,0, 0,0,0,  0,32, 1,16,0,0, 0,4));
    vecs.push_back(mk(0,1,1,0, 0,0, 0,0,0,  0,32, 1,16,0,0, 0,4));
    vecs.push_back(mk(0,0,1,1, 0,0, 0,0,0,  0,32, 1,16,0,0, 0,4));
    vecs.push_back(mk(0,0,1,1, 0,0, 0,0,0,  0,32, 1,20,0,0, 0,3));
    vecs.push_back(mk(0,0,1,1, 0,0, 0,0,0,  0,32, 1,24,0,0, 0,2));
    vecs.push_back(mk(0,0,1,1, 0,0, 0,0,0,  0,32, 1,28,0,0, 0,1));
    vecs.push_back(mk(0,0,1,1, 0,0, 0,0,0,  0,32, 0,0,0,0,  0,0));
    // Redirect with two requests in flight
    vecs.push_back(mk(0,1,1,1, 0,0,       0,0,0,       1,32,      0,0,0,0,       0,0));
    vecs.push_back(mk(0,1,1,1, 0,0,       0,0,0,       1,36,      0,0,0,0,       1,0));
    vecs.push_back(mk(0,1,1,1, 1,'h1000,  0,0,0,       0,40,      0,0,0,0,       2,0));
    vecs.push_back(mk(0,1,1,1, 0,0,       1,32,0,      0,'h1000,  0,0,0,0,       2,0));
    vecs.push_back(mk(0,1,1,1, 0,0,       1,36,0,      1,'h1000,  0,0,0,0,       1,0));
    vecs.push_back(mk(0,1,1,1, 0,0,       1,'h1000,0,  1,'h1004,  0,0,0,0,       1,0));
    vecs.push_back(mk(0,0,1,1, 0,0,       1,'h1004,0,  0,'h1008,  1,'h1000,0,0,  1,1));
    vecs.push_back(mk(0,0,1,1, 0,0,       0,0,0,       0,'h1008,  1,'h1004,0,0,  0,1));
    // Redirect coincident with a response: that response and one more are dropped
    vecs.push_back(mk(0,1,1,1, 0,0,       0,0,0,       1,'h1008,  0,0,0,0,       0,0));
    vecs.push_back(mk(0,1,1,1, 0,0,       0,0,0,       1,'h100C,  0,0,0,0,       1,0));
    vecs.push_back(mk(0,1,1,1, 1,'h2000,  1,'h1008,0,  0,'h1010,  0,0,0,0,       2,0));
    vecs.push_back(mk(0,1,1,1, 0,0,       1,'h100C,0,  1,'h2000,  0,0,0,0,       1,0));
    vecs.push_back(mk(0,0,1,1, 0,0,       1,'h2000,0,  0,'h2004,  0,0,0,0,       1,0));
    vecs.push_back(mk(0,0,1,1, 0,0,       0,0,0,       0,'h2004,  1,'h2000,0,0,  0,1));
    vecs.push_back(mk(0,0,1,1, 0,0,       0,0,0,       0,'h2004,  0,0,0,0,       0,0));
    // ECALL at 0x8 with 0xC in flight, then redirect to 0x200 flushes and resumes
    vecs.push_back(mk(0,1,1,0, 1,'h8,     0,0,0,       0,'h2004,  0,0,0,0,       0,0));
    vecs.push_back(mk(0,1,1,0, 0,0,       0,0,0,       1,'h8,     0,0,0,0,       0,0));
    vecs.push_back(mk(0,1,1,0, 0,0,       0,0,0,       1,'hC,     0,0,0,0,       1,0));
    vecs.push_back(mk(0,1,1,0, 0,0,       1,'h8,1,     0,'h10,    0,0,0,0,       2,0));
    vecs.push_back(mk(0,1,1,0, 0,0,       1,'hC,0,     0,'h10,    1,'h8,1,1,     1,1));
    vecs.push_back(mk(0,1,1,0, 0,0,       0,0,0,       0,'h10,    1,'h8,1,1,     0,1));
    vecs.push_back(mk(0,1,1,0, 1,'h200,   0,0,0,       0,'h10,    1,'h8,1,1,     0,1));
    vecs.push_back(mk(0,1,1,1, 0,0,       0,0,0,       1,'h200,   0,0,0,0,       0,0));
    vecs.push_back(mk(0,0,1,1, 0,0,       1,'h200,0,   0,'h204,   0,0,0,0,       1,0));
    vecs.push_back(mk(0,0,1,1, 0,0,       0,0,0,       0,'h204,   1,'h200,0,0,   0,1));
    // PC wrap at 2^64-4, then reset mid-stream
    vecs.push_back(mk(0,1,1,0, 1,64'hFFFF_FFFF_FFFF_FFFC, 0,0,0, 0,'h204, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,1,1,0, 0,0, 0,0,0, 1,64'hFFFF_FFFF_FFFF_FFFC, 0,0,0,0, 0,0));
    vecs.push_back(mk(0,1,1,0, 0,0, 1,64'hFFFF_FFFF_FFFF_FFFC,0, 1,0, 0,0,0,0, 1,0));
    vecs.push_back(mk(1,1,1,0, 0,0, 1,0,0, 1,4, 1,64'hFFFF_FFFF_FFFF_FFFC,0,0, 1,1));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0, 0,0, 0,0,0,0, 0,0));

    drive_idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset            = vecs[i].rst;
      fetch_enable     = vecs[i].fe;
      bus.ic_req_ready = vecs[i].rdy;
      bus.out_ready    = vecs[i].ordy;
      redirect_valid   = vecs[i].rv;
      redirect_pc      = vecs[i].rpc;
      bus.ic_resp_valid = vecs[i].resp_v;
      bus.ic_resp_pc   = vecs[i].resp_pc;
      bus.ic_resp_inst = vecs[i].resp_ec ? 32'h0000_0073 : inst_of(vecs[i].resp_pc);
      #1;
      exp_inst = !vecs[i].e_out_v ? 32'h0 :
                 (vecs[i].e_ec ? 32'h0000_0073 : inst_of(vecs[i].e_out_pc));
      chk($sformatf("row%0d ic_req_valid", i), 64'(bus.ic_req_valid), 64'(vecs[i].e_req_v));
      chk($sformatf("row%0d ic_req_pc", i), bus.ic_req_pc, vecs[i].e_req_pc);
      chk($sformatf("row%0d out_valid", i), 64'(bus.out_valid), 64'(vecs[i].e_out_v));
      chk($sformatf("row%0d out_pc", i), bus.out_pc, vecs[i].e_out_pc);
      chk($sformatf("row%0d out_inst", i), 64'(bus.out_inst), 64'(exp_inst));
      chk($sformatf("row%0d out_is_ecall", i), 64'(bus.out_is_ecall), 64'(vecs[i].e_ec));
      chk($sformatf("row%0d ecall_halted", i), 64'(ecall_halted), 64'(vecs[i].e_halt));
      chk($sformatf("row%0d inflight", i), 64'(inflight), 64'(vecs[i].e_infl));
      chk($sformatf("row%0d occupancy", i), 64'(occupancy), 64'(vecs[i].e_occ));
    end

    // Free-running stream from reset: gapless 0,4,8,... with a one-cycle icache model
    pend_v = 1'b0; pend_pc = 64'h0; exp_pc = 64'h0; got = 0; max_infl = 0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      reset = 1'b0; redirect_valid = 1'b0;
      fetch_enable = 1'b1; bus.ic_req_ready = 1'b1; bus.out_ready = 1'b1;
      bus.ic_resp_valid = pend_v;
      bus.ic_resp_pc    = pend_pc;
      bus.ic_resp_inst  = inst_of(pend_pc);
      #1;
      if (int'(inflight) > max_infl) max_infl = int'(inflight);
      if (bus.out_valid) begin
        chk("stream out_pc", bus.out_pc, exp_pc);
        chk("stream out_inst", 64'(bus.out_inst), 64'(inst_of(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        got++;
      end else if (got > 0) begin
        chk("stream bubble", 64'(bus.out_valid), 64'(1'b1));
      end
      pend_v  = bus.ic_req_valid;
      pend_pc = bus.ic_req_pc;
    end
    chk("stream outputs received", 64'(got), 64'(8));
    chk("stream inflight bound", 64'(max_infl <= 2), 64'(1'b1));

    drive_idle();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Parametrised successor to the single-entry fetch stage. It sits between the PC and redirect logic and the decode stage. It issues up to MAX_OUTSTANDING in-order requests to the instruction cache and buffers returned instructions in a DEPTH-entry FIFO. It discards stale responses after a redirect and halts sequential fetch after an ECALL. Decode consumes instructions through a valid/ready handshake instead of the if_id_valid/complete pairing.

Parameters:
XLEN, 64, PC and address width
ILEN, 32, instruction width
DEPTH, 4, FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 2, in-flight icache requests (>=1, <=DEPTH)
RESET_PC, 64'h0, PC loaded on reset

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
fetch_enable  in  1  permits new icache requests
redirect_valid  in  1  jump/branch/trap redirect this cycle
redirect_pc  in  XLEN  redirect target
ic_req_valid  out  1  request to icache
ic_req_ready  in  1  icache accepts request
ic_req_pc  out  XLEN  request address
ic_resp_valid  in  1  in-order response, one-cycle pulse, always accepted
ic_resp_inst  in  ILEN  returned instruction
ic_resp_pc  in  XLEN  PC of returned instruction
out_valid  out  1  FIFO head valid
out_ready  in  1  decode accepts head
out_inst  out  ILEN  head instruction
out_pc  out  XLEN  head PC
out_is_ecall  out  1  head instruction == 32'h00000073
ecall_halted  out  1  fetch halted after ECALL
inflight  out  $clog2(MAX_OUTSTANDING+1)  outstanding request count
occupancy  out  $clog2(DEPTH+1)  FIFO entry count

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC.
  - FIFO empty; inflight = 0; drop_cnt = 0; ecall_halted = 0.
  - All outputs 0, except ic_req_pc = RESET_PC.
- Issue rule: ic_req_valid = fetch_enable & !ecall_halted & !redirect_valid & (inflight < MAX_OUTSTANDING) & (occupancy + inflight - drop_cnt < DEPTH).
  - This credit check guarantees a response can never overflow the FIFO.
- ic_req_pc = fetch_pc. On ic_req_valid & ic_req_ready, fetch_pc <= fetch_pc + 4, wrapping modulo 2^XLEN.
- inflight: +1 on request handshake, -1 on ic_resp_valid. Both in one cycle leaves it unchanged.
- Response with drop_cnt > 0: discarded and drop_cnt decrements. Otherwise the response is pushed at the tail.
  - is_ecall is computed and stored per entry at push.
- Push of an ECALL: ecall_halted <= 1 and drop_cnt <= inflight_after_this_cycle, so younger in-flight responses are discarded. Queued entries older than the ECALL are kept.
- Output: out_* reflect the head combinationally from registered storage, so latency is response-to-out_valid = 1 cycle.
  - Pop occurs on out_valid & out_ready.
  - Push and pop in the same cycle are allowed, including when full. Occupancy is then unchanged.
- Redirect (highest priority):
  - FIFO flushed and occupancy <= 0.
  - fetch_pc <= redirect_pc; ecall_halted <= 0.
  - drop_cnt <= inflight - (ic_resp_valid ? 1 : 0). Any response arriving that cycle is discarded.
  - No request is issued in the redirect cycle. An out_ready handshake in that cycle completes at decode, but the FIFO flush still applies.
- A redirect while drop_cnt > 0 recomputes drop_cnt from inflight, so older drops are preserved. Back-to-back redirects use the last target.
- fetch_enable low blocks only issue. Responses are still accepted and output still drains.
- ic_resp_pc is stored unchanged and is not checked against fetch_pc.
- Reset mid-operation: all state returns to reset values. Responses arriving after reset for pre-reset requests are dropped only if the icache is also reset; the icache shares the same reset.

Decomposition:
- Shared package fetch_pkg holds:
  - ECALL_INST = 32'h00000073
  - INST_BYTES = 4
  - a packed struct fetch_entry_t {pc, inst, is_ecall} reused by decode.
- One sub-module, fetch_fifo: a parametrised synchronous FIFO over fetch_entry_t with push, pop, flush, count, and simultaneous push/pop when full.
- Issue, credit, drop and halt logic stay in the top level.

Test Plan:
- Streaming: reset, fetch_enable=1, icache ready with 1-cycle response, out_ready=1 -> out_pc sequence 0,4,8,12; no bubbles after the first; inflight never exceeds 2.
- Backpressure: out_ready=0 with DEPTH=4 -> exactly 4 entries, then ic_req_valid stays low. Release out_ready -> in-order drain with no loss and no duplicates.
- Redirect with 2 in flight: redirect_pc=0x1000 -> next 2 responses discarded, FIFO empty, next out_pc=0x1000.
- Redirect coincident with a response: response dropped, drop_cnt = 1.
- ECALL at pc 0x8 with request 0xC in flight -> out_is_ecall=1 at 0x8, 0xC discarded, ecall_halted=1, no requests issued. Then redirect to 0x200 -> halt clears and fetch resumes at 0x200.
- Wrap and reset: fetch_pc = 2^64-4 -> next request pc = 0. Assert reset mid-stream -> all outputs at reset values next cycle and ic_req_pc = RESET_PC.
